// File: rtl/median_filter_3x3_pkg.sv
// median_filter_3x3_pkg: geometry, pipeline latency and 3-input selection helpers
package median_filter_3x3_pkg;
   localparam int HOR_ADDR_TIME = 800;
   localparam int VER_ADDR_TIME = 600;
   localparam int WIDTH         = HOR_ADDR_TIME >> 1;
   localparam int HEIGHT        = VER_ADDR_TIME >> 1;
   localparam int PIX_W         = 8;
   localparam int MED_LAT       = 3;
   localparam int XW            = $clog2(WIDTH);
   localparam int YW            = $clog2(HEIGHT);

   typedef logic [PIX_W-1:0] pix_t;
   typedef pix_t [2:0] col_t;

   typedef struct packed {
      logic v;
      logic c;
   } tag_t;

   function automatic pix_t min2(input pix_t a, input pix_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic pix_t max2(input pix_t a, input pix_t b);
      return (a < b) ? b : a;
   endfunction

   function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
      return min2(min2(a, b), c);
   endfunction

   function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
      return max2(max2(a, b), c);
   endfunction

   function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
      return max2(min2(a, b), min2(max2(a, b), c));
   endfunction
endpackage

// File: rtl/median_filter_3x3_sort3.sv
// sort3: combinational sort of three pixels, packed as {max, mid, min}
module sort3
   import median_filter_3x3_pkg::*;
(
   input  col_t in_i,
   output col_t srt_o
);
   assign srt_o = {max3(in_i[2], in_i[1], in_i[0]),
                   med3(in_i[2], in_i[1], in_i[0]),
                   min3(in_i[2], in_i[1], in_i[0])};
endmodule

// File: rtl/median_filter_3x3.sv
// median_filter_3x3: 2:1 decimating 3x3 median filter over an 800x600 pixel stream
module median_filter_3x3
   import median_filter_3x3_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [10:0]      hcount,
   input  logic [10:0]      vcount,
   input  logic [PIX_W-1:0] gray_value,
   output logic [PIX_W-1:0] median_value,
   output logic             median_valid
);
   logic                s;
   logic [XW-1:0]       x;
   logic [YW-1:0]       y;
   logic                frame_ok_q, frame_ok_d;
   pix_t                lb1_q [WIDTH];
   pix_t                lb2_q [WIDTH];
   pix_t                lb1_rd, lb2_rd;
   col_t [2:0]          win_q, st1_d, st1_q;
   col_t                st2_d, st2_q;
   tag_t [MED_LAT-1:0]  tag_q;
   tag_t                tag_d;
   pix_t                median_q, median_d;
   logic                valid_q;

   assign x = hcount[XW:1];
   assign y = vcount[YW:1];
   assign s = ~hcount[0] & ~vcount[0] & (hcount < 11'(HOR_ADDR_TIME)) & (vcount < 11'(VER_ADDR_TIME));
   assign frame_ok_d = frame_ok_q | ((hcount == 11'd0) & (vcount == 11'd0));
   assign lb1_rd = lb1_q[x];
   assign lb2_rd = lb2_q[x];

   // line buffers are never reset; rows y<2 are masked by the completeness flag
   always_ff @(posedge clk) begin
      if (s) begin
         lb1_q[x] <= gray_value;
         lb2_q[x] <= lb1_rd;
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_col
      sort3 u_sort3 (.in_i(win_q[i]), .srt_o(st1_d[i]));
   end

   always_comb begin
      tag_d    = '{v: s & frame_ok_d, c: (x >= XW'(2)) & (y >= YW'(2))};
      st2_d    = {min3(st1_q[0][2], st1_q[1][2], st1_q[2][2]),
                  med3(st1_q[0][1], st1_q[1][1], st1_q[2][1]),
                  max3(st1_q[0][0], st1_q[1][0], st1_q[2][0])};
      median_d = tag_q[MED_LAT-1].v ? (tag_q[MED_LAT-1].c ? med3(st2_q[0], st2_q[1], st2_q[2]) : '0) : median_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_ok_q <= 1'b0;
         win_q      <= '0;
         st1_q      <= '0;
         st2_q      <= '0;
         tag_q      <= '0;
         median_q   <= '0;
         valid_q    <= 1'b0;
      end else begin
         frame_ok_q <= frame_ok_d;
         if (s) win_q <= {lb2_rd, lb1_rd, gray_value, win_q[2:1]};
         st1_q      <= st1_d;
         st2_q      <= st2_d;
         tag_q      <= {tag_q[MED_LAT-2:0], tag_d};
         median_q   <= median_d;
         valid_q    <= tag_q[MED_LAT-1].v;
      end
   end

   assign median_value = median_q;
   assign median_valid = valid_q;
endmodule

// File: tb/tb_median_filter_3x3.sv
// tb_median_filter_3x3: randomized raster stimulus checked against an image-array median model
module tb_median_filter_3x3;
   logic        clk;
   logic        rst;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic [7:0]  gray_value;
   logic [7:0]  median_value;
   logic        median_valid;

   typedef struct {
      bit         v;
      bit         c;
      logic [7:0] val;
      int         x;
      int         y;
      int         pat;
   } exp_t;

   exp_t       q[$];
   logic [7:0] img [300][400];
   int         perm [9];
   int         checks = 0;
   int         errors = 0;
   int         cur_pat = 3;
   bit         fo = 1'b0;
   logic [7:0] exp_val = 8'h00;

   median_filter_3x3 dut (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
      .gray_value(gray_value), .median_value(median_value), .median_valid(median_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] med9(input int x, input int y);
      logic [7:0] a [9];
      logic [7:0] t;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            a[r*3+c] = img[y-2+r][x-2+c];
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      return a[4];
   endfunction

   function automatic logic [7:0] pix(input int pat, input int x, input int y);
      case (pat)
         0: return 8'h80;
         1: return (x == 10 && y == 10) ? 8'hFF : 8'h10;
         2: return (x < 100) ? 8'h00 : 8'hFF;
         4: return (x >= 5 && x <= 7 && y >= 5 && y <= 7) ? 8'(perm[(y-5)*3 + x-5]) : 8'($urandom);
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic reset_model();
      exp_t e;
      e = '{v: 1'b0, c: 1'b0, val: 8'h00, x: 0, y: 0, pat: 0};
      q.delete();
      repeat (3) q.push_back(e);
      fo = 1'b0;
      exp_val = 8'h00;
   endtask

   task automatic drive(input int h, input int v, input logic [7:0] g);
      exp_t       e;
      bit         s;
      int         k;
      logic [7:0] l1, l2;
      s = (h % 2 == 0) && (v % 2 == 0) && (h < 800) && (v < 600);
      if (h == 0 && v == 0) fo = 1'b1;
      e.x = h / 2; e.y = v / 2; e.pat = cur_pat;
      e.v = s && fo;
      e.c = s && e.x >= 2 && e.y >= 2;
      e.val = 8'h00;
      if (s) begin
         img[e.y][e.x] = g;
         if (e.c) e.val = med9(e.x, e.y);
      end
      k = (e.x < 400) ? e.x : 0;
      l1 = dut.lb1_q[k];
      l2 = dut.lb2_q[k];
      hcount = 11'(h); vcount = 11'(v); gray_value = g;
      q.push_back(e);
      @(posedge clk); #1;
      if (!s) begin
         checks++;
         if (dut.lb1_q[k] !== l1) begin errors++; $display("FAIL lb1_hold h=%0d v=%0d got %0h exp %0h", h, v, dut.lb1_q[k], l1); end
         checks++;
         if (dut.lb2_q[k] !== l2) begin errors++; $display("FAIL lb2_hold h=%0d v=%0d got %0h exp %0h", h, v, dut.lb2_q[k], l2); end
      end
      e = q.pop_front();
      checks++;
      if (median_valid !== e.v) begin errors++; $display("FAIL valid x=%0d y=%0d got %b exp %b", e.x, e.y, median_valid, e.v); end
      if (e.v) exp_val = e.val;
      checks++;
      if (median_value !== exp_val) begin errors++; $display("FAIL value x=%0d y=%0d got %0h exp %0h", e.x, e.y, median_value, exp_val); end
      if (e.v) begin
         if (!e.c) begin
            checks++;
            if (median_value !== 8'h00) begin errors++; $display("FAIL border x=%0d y=%0d got %0h exp 0", e.x, e.y, median_value); end
         end else if (e.pat == 0) begin
            checks++;
            if (median_value !== 8'h80) begin errors++; $display("FAIL flat x=%0d y=%0d got %0h exp 80", e.x, e.y, median_value); end
         end else if (e.pat == 1) begin
            checks++;
            if (median_value !== 8'h10) begin errors++; $display("FAIL impulse x=%0d y=%0d got %0h exp 10", e.x, e.y, median_value); end
         end else if (e.pat == 2 && e.x == 100) begin
            checks++;
            if (median_value !== 8'h00) begin errors++; $display("FAIL edge_lo y=%0d got %0h exp 0", e.y, median_value); end
         end else if (e.pat == 2 && e.x == 101) begin
            checks++;
            if (median_value !== 8'hFF) begin errors++; $display("FAIL edge_hi y=%0d got %0h exp ff", e.y, median_value); end
         end else if (e.pat == 4 && e.x == 7 && e.y == 7) begin
            checks++;
            if (median_value !== 8'h05) begin errors++; $display("FAIL win19 got %0h exp 5", median_value); end
         end
      end
   endtask

   task automatic run_rows(input int pat, input int y0, input int y1, input int cols);
      cur_pat = pat;
      for (int y = y0; y < y1; y++) begin
         for (int x = 0; x < cols; x++) begin
            drive(2*x, 2*y, pix(pat, x, y));
            drive(2*x + 1, 2*y, 8'($urandom));
         end
         drive(800, 2*y, 8'($urandom));
         drive(801, 2*y, 8'($urandom));
         drive(1000, 2*y, 8'($urandom));
         for (int i = 0; i < 4; i++) drive(i, 2*y + 1, 8'($urandom));
      end
   endtask

   task automatic run_frame(input int pat, input int cols, input int rows);
      run_rows(pat, 0, rows, cols);
      drive(0, 600, 8'($urandom));
      drive(2, 601, 8'($urandom));
      drive(400, 1000, 8'($urandom));
   endtask

   task automatic test_reset();
      rst = 1'b0; hcount = 11'd5; vcount = 11'd300; gray_value = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (median_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", median_valid); end
      checks++;
      if (median_value !== 8'h00) begin errors++; $display("FAIL rst_value got %0h exp 0", median_value); end
      rst = 1'b1;
      reset_model();
      cur_pat = 3;
      for (int y = 150; y < 152; y++)
         for (int x = 0; x < 16; x++) begin
            drive(2*x, 2*y, 8'($urandom));
            drive(2*x + 1, 2*y, 8'($urandom));
         end
      run_frame(3, 24, 6);
   endtask

   task automatic test_flat();
      run_frame(0, 24, 14);
      run_frame(0, 24, 14);
   endtask

   task automatic test_impulse();
      run_frame(1, 24, 14);
   endtask

   task automatic test_window_1to9();
      int j, t;
      for (int i = 0; i < 9; i++) perm[i] = i + 1;
      for (int i = 8; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      run_frame(4, 12, 10);
   endtask

   task automatic test_vertical_edge();
      run_frame(2, 104, 5);
   endtask

   task automatic test_random();
      run_frame(3, 24, 14);
   endtask

   task automatic test_mid_reset();
      run_rows(3, 0, 3, 10);
      drive(0, 6, 8'($urandom));
      drive(2, 6, 8'($urandom));
      rst = 1'b0;
      #2;
      checks++;
      if (median_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", median_valid); end
      checks++;
      if (median_value !== 8'h00) begin errors++; $display("FAIL mid_rst_value got %0h exp 0", median_value); end
      @(posedge clk); #1;
      rst = 1'b1;
      reset_model();
      run_rows(3, 4, 6, 10);
      run_frame(3, 24, 8);
   endtask

   task automatic test_blanking();
      cur_pat = 3;
      for (int i = 0; i < 20; i++) begin
         drive(int'($urandom_range(399, 0)) * 2 + 1, int'($urandom_range(299, 0)) * 2, 8'($urandom));
         drive(int'($urandom_range(799, 0)), int'($urandom_range(299, 0)) * 2 + 1, 8'($urandom));
         drive(int'($urandom_range(1055, 800)), int'($urandom_range(627, 0)), 8'($urandom));
      end
   endtask

   initial begin
      rst = 1'b0;
      hcount = '0; vcount = '0; gray_value = '0;
      test_reset();
      test_flat();
      test_impulse();
      test_window_1to9();
      test_vertical_edge();
      test_random();
      test_blanking();
      test_mid_reset();
      test_blanking();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
